// File: rtl/pq_op_scheduler.sv
// Round-robin front end that serialises NUM_REQ requesters onto one systolic priority queue,
// issuing one single-cycle queue op at a time and pacing issue by the queue's settle time.
module pq_op_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ENQ_SETTLE = 2,
  parameter int unsigned DEQ_SETTLE = 3
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [2*NUM_REQ-1:0]          i_req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    o_rsp_id,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic [1:0]                    o_rsp_status,
  output logic                          o_q_wrt,
  output logic                          o_q_read,
  output logic [DATA_WIDTH-1:0]         o_q_data,
  input  logic                          i_q_full,
  input  logic                          i_q_empty,
  input  logic [DATA_WIDTH-1:0]         i_q_data
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  localparam logic [1:0] OpEnq  = 2'b00;
  localparam logic [1:0] OpDeq  = 2'b01;
  localparam logic [1:0] OpRepl = 2'b10;
  localparam logic [1:0] OpPeek = 2'b11;

  localparam logic [1:0] StatOk       = 2'b00;
  localparam logic [1:0] StatRejFull  = 2'b01;
  localparam logic [1:0] StatRejEmpty = 2'b10;

  typedef enum logic [1:0] {StIdle, StIssue, StSettle, StResp} state_e;

  state_e                state_q, state_d;
  logic [IdW-1:0]        rr_q, id_q, gnt_idx;
  logic                  gnt_found;
  logic [1:0]            op_q, status_q;
  logic [DATA_WIDTH-1:0] data_q, rsp_data_q, q_data_q;
  logic                  wrt_q, read_q;
  logic [7:0]            cnt_q;
  logic                  iss_wrt, iss_read;
  logic [1:0]            iss_status;
  logic [7:0]            iss_settle;

  // First valid requester at or after rr_q, searching cyclically.
  always_comb begin
    logic [IdW-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IdW'((32'(rr_q) + i) % NUM_REQ);
      if (!gnt_found && i_req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    iss_wrt    = 1'b0;
    iss_read   = 1'b0;
    iss_status = StatOk;
    iss_settle = '0;
    unique case (op_q)
      OpEnq: begin
        if (!i_q_full) begin
          iss_wrt    = 1'b1;
          iss_settle = 8'(ENQ_SETTLE);
        end else begin
          iss_status = StatRejFull;
        end
      end
      OpDeq: begin
        if (!i_q_empty) begin
          iss_read   = 1'b1;
          iss_settle = 8'(DEQ_SETTLE);
        end else begin
          iss_status = StatRejEmpty;
        end
      end
      OpRepl: begin
        if (!i_q_empty) begin
          iss_wrt    = 1'b1;
          iss_read   = 1'b1;
          iss_settle = 8'(ENQ_SETTLE);
        end else begin
          iss_status = StatRejEmpty;
        end
      end
      OpPeek: begin
        if (i_q_empty) iss_status = StatRejEmpty;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Strobe-less ops pass through SETTLE with a zero count, so every response lands at
  // grant + 3 + settle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (gnt_found) state_d = StIssue;
      StIssue:  state_d = StSettle;
      StSettle: if (cnt_q == 8'd0) state_d = StResp;
      StResp:   state_d = StIdle;
    endcase
  end

  always_comb begin
    o_req_ready = '0;
    if (state_q == StIdle && gnt_found) o_req_ready[gnt_idx] = 1'b1;
    o_rsp_valid = (state_q == StResp);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      rr_q       <= '0;
      id_q       <= '0;
      op_q       <= OpEnq;
      data_q     <= '0;
      rsp_data_q <= '0;
      status_q   <= StatOk;
      q_data_q   <= '0;
      wrt_q      <= 1'b0;
      read_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wrt_q  <= (state_q == StIssue) && iss_wrt;
      read_q <= (state_q == StIssue) && iss_read;
      if (state_q == StIdle && gnt_found) begin
        op_q   <= i_req_op[32'(gnt_idx)*2 +: 2];
        data_q <= i_req_data[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        id_q   <= gnt_idx;
        rr_q   <= IdW'((32'(gnt_idx) + 32'd1) % NUM_REQ);
      end
      if (state_q == StIssue) begin
        rsp_data_q <= i_q_data;
        status_q   <= iss_status;
        cnt_q      <= iss_settle;
        if (iss_wrt) q_data_q <= data_q;
      end
      if (state_q == StSettle && cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
    end
  end

  assign o_rsp_id     = id_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_status = status_q;
  assign o_q_wrt      = wrt_q;
  assign o_q_read     = read_q;
  assign o_q_data     = q_data_q;

endmodule
